// File: rtl/irq_encoder8.sv
// irq_encoder8: sticky 8-line event capture with per-line mask, lowest-index
// priority selection and a valid/ack handshake on the presented 3-bit code.
module irq_encoder8 #(
  parameter int EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       code_ack,
  output logic       code_valid,
  output logic [2:0] code,
  output logic [7:0] pending,
  output logic       overflow
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] req_q;
  logic [7:0] ev;
  logic [7:0] clr;
  logic [7:0] elig;
  logic [7:0] pending_nxt;
  logic [2:0] sel;
  logic [2:0] code_nxt;
  logic       valid_nxt;
  logic       overflow_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= req;
      pending    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      req_q      <= req;
      pending    <= pending_nxt;
      code       <= code_nxt;
      code_valid <= valid_nxt;
      overflow   <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (elig != '0) state_nxt = PRESENT;
      PRESENT: if (code_ack)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ev           = (EDGE_MODE != 0) ? (req & ~req_q) : req;
    clr          = (code_valid && code_ack) ? (8'b1 << code) : '0;
    // Set dominates clear so an event landing on the acked line is kept.
    pending_nxt  = (pending & ~clr) | ev;
    elig         = pending & ~mask;
    overflow_nxt = (EDGE_MODE != 0) ? |(ev & pending & ~clr) : 1'b0;

    sel = '0;
    for (int unsigned i = 8; i > 0; i--) begin
      if (elig[i-1]) sel = 3'(i - 1);
    end

    code_nxt = code;
    if (state == IDLE && elig != '0) code_nxt = sel;
    valid_nxt = (state_nxt == PRESENT);
  end

endmodule
